// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcode constants, the fetch
// step, the default reset PC, the fetch FSM encoding and the queue entry
// layout used between the fetch unit and its buffer.
package mips_pkg;

    // Major opcodes the control decoder keys on (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_STEP = 32'd4;

    // PC loaded at reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // one settling cycle after reset release
        REQ   = 2'd1,   // normal fetching, gated by queue space
        DRAIN = 2'd2    // waiting out a request made stale by a redirect
    } fetchState_t;

    // One queued instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// A push and a pop may happen in the same cycle even when full; flush
// empties the queue in one cycle. Popped slots keep their contents.
module fetch_buffer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetchEntry_t pushEntry,
    output logic [1:0]  count,
    output fetchEntry_t headEntry
);

    fetchEntry_t entries [2];
    logic        rdPtr;
    logic        wrPtr;

    // Entry storage: written on push, suppressed while flushing.
    // NOTE: the storage is reset (it is only two entries) because the head
    // outputs must read as zero straight out of reset; a deeper queue would
    // leave the array unreset and rely on count to qualify the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (push && !flush) begin
            entries[wrPtr] <= pushEntry;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: every register here uses <= so all right-hand sides see the
    // values from before this edge; blocking = would make count depend on
    // statement order and break the simultaneous push/pop case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wrPtr <= rdPtr;
            count <= 2'd0;
        end else begin
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign headEntry = entries[rdPtr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one word request at a time
// over imem_req/imem_ack, queues returned words in a 2-entry buffer and
// hands them to decode over if_valid/id_ready. A taken branch flushes the
// queue and restarts fetch at the target; a request already in flight is
// drained and its word discarded.
// Optional build macro IFETCH_PERF_EN adds perf_fetched/perf_stall counters.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [5:0]  if_opcode,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetchState_t state;
    fetchState_t stateNext;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] pendPc;
    logic [31:0] pendPcNext;
    logic        armed;

    logic        push;
    logic        pop;
    logic        flush;
    logic        popReq;
    logic [1:0]  count;
    logic [31:0] target;
    fetchEntry_t headEntry;
    fetchEntry_t pushEntry;

    assign target    = wordAlign(redirect_pc);
    assign popReq    = if_valid && id_ready;
    assign pushEntry = '{pc: pc, instr: imem_rdata};

    // State, PC and pending redirect target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            pendPc <= RESET_PC;
            armed  <= 1'b0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            pendPc <= pendPcNext;
            // The first edge after reset release only arms the FSM, so
            // IDLE occupies one full clock cycle before fetching starts.
            armed  <= 1'b1;
        end
    end

    // Next-state, request gating and queue control.
    // NOTE: every output of this block is given a default before the case
    // statement; a path that left one unassigned would infer a latch.
    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        pendPcNext = pendPc;
        imem_req   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pcNext = target;
                end
                if (armed) begin
                    stateNext = REQ;
                end
            end

            REQ: begin
                // Request only when the word has somewhere to land, counting
                // a slot freed by this cycle's pop. Occupancy never rises
                // while a request waits, so a raised request stays raised.
                imem_req = (count < 2'd2) || popReq;
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (imem_req && !imem_ack) begin
                        // The in-flight request must complete at its
                        // original address; remember where to go after.
                        stateNext  = DRAIN;
                        pendPcNext = target;
                    end else begin
                        // Nothing outstanding, or it completes now and the
                        // word is simply dropped.
                        pcNext = target;
                    end
                end else begin
                    pop = popReq;
                    if (imem_req && imem_ack) begin
                        push   = 1'b1;
                        pcNext = pc + PC_STEP;
                    end
                end
            end

            DRAIN: begin
                // Hold the stale request until memory answers; the queue is
                // already empty, and later redirects only retarget.
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pendPcNext = target;
                end
                if (imem_ack) begin
                    stateNext = REQ;
                    pcNext    = redirect_valid ? target : pendPc;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .pushEntry (pushEntry),
        .count     (count),
        .headEntry (headEntry)
    );

    assign if_valid  = (count != 2'd0);
    assign if_instr  = headEntry.instr;
    assign if_pc     = headEntry.pc;
    assign if_opcode = headEntry.instr[31:26];

`ifdef IFETCH_PERF_EN
    // Free-running counters of delivered instructions and decode stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_stall   <= perf_stall + 32'(if_valid && !id_ready);
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue MIPS datapath: it produces the instruction stream that the opcode decoder consumes. It holds the PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered in a 2-entry queue and presented to decode with a valid/ready handshake. Branch redirects from the execute stage flush the queue and restart fetch at the target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded at reset. Bits [1:0] must be 0.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: word address of the request, byte-addressed, bits [1:0] = 0.
- `imem_ack` input 1: memory completes the current request this cycle.
- `imem_rdata` input 32: instruction word; valid only when `imem_ack` = 1.
- `if_valid` output 1: the queue head holds a valid instruction.
- `if_instr` output 32: queue-head instruction.
- `if_pc` output 32: PC of the queue-head instruction.
- `if_opcode` output 6: equals `if_instr[31:26]`; feeds the control decoder.
- `id_ready` input 1: decode accepts the head this cycle.
- `redirect_valid` input 1: branch taken; restart fetch.
- `redirect_pc` input 32: branch target. Bits [1:0] are ignored and forced to 0.

## Operation
- **FSM states:** IDLE, REQ, DRAIN.
  - **IDLE:** entered only from reset. Lasts one cycle, then moves to REQ.
  - **REQ:** `imem_req` = 1 while `occupancy + 1 <= 2` counting an entry freed by a pop this cycle. Otherwise `imem_req` = 0 and the FSM waits in REQ.
    - On a cycle with `imem_req` & `imem_ack`: push {pc, `imem_rdata`} and set pc = pc + 4.
    - pc wraps modulo 2^32, so `32'hFFFF_FFFC` is followed by `0`.
  - **DRAIN:** entered when a redirect arrives while a request is outstanding (`imem_req` = 1 and no `imem_ack` that cycle).
    - `imem_req` and `imem_addr` stay unchanged until `imem_ack`.
    - The acked word is discarded; the FSM then returns to REQ at the redirect target.
- **Memory handshake:**
  - Exactly one request is outstanding at a time.
  - Once raised, `imem_req` and `imem_addr` stay stable until the ack cycle.
  - A zero-wait memory may ack in the same cycle as the request.
- **Redirect:**
  - Flushes the queue: `if_valid` = 0 next cycle.
  - pc is set to `{redirect_pc[31:2], 2'b00}`.
  - A same-cycle `imem_ack` is discarded, with no push.
  - A same-cycle pop is ignored.
  - A redirect during DRAIN overwrites the pending target; draining continues.
- **Queue:**
  - Pop when `if_valid` & `id_ready`.
  - Push and pop in the same cycle are allowed when full.
  - The queue never overflows: the request gating guarantees space.
  - Entries retain their last values after a pop.

## Timing
- **Reset values:** `imem_req` = 0, `imem_addr` = `RESET_PC`, `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_opcode` = 0, FSM = IDLE, queue empty.
- **First request:** `rst_n` deasserts before edge 0; `imem_req` = 1 after edge 1 (one IDLE cycle).
- **Ack to output:** an ack on edge k gives `if_valid` = 1 with that word after edge k.
- **Throughput:** with a zero-wait memory and `id_ready` = 1 held, one instruction per cycle.
- **Redirect latency:** `redirect_valid` at edge r gives `imem_addr` = target at edge r+1 when no request is outstanding. With an outstanding request, `imem_addr` = target one cycle after the draining ack.
- **Output stability:** `if_instr` and `if_pc` hold while `if_valid` & !`id_ready`.
- **Asynchronous reset mid-operation:** all outputs go to their reset values immediately. Any in-flight memory response is ignored, because `imem_req` = 0.

## Configuration
- Macro: `IFETCH_PERF_EN`.
- **Defined:** adds two output ports, each reset to 0 and wrapping at 2^32.
  - `perf_fetched` (32): increments on every pop.
  - `perf_stall` (32): increments on every cycle with `if_valid` & !`id_ready`.
- **Undefined:** the ports and counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package `mips_pkg`:**
  - Opcode constants `OP_RTYPE` = `6'b000000`, `OP_LW` = `6'b100011`, `OP_SW` = `6'b101011`, `OP_BEQ` = `6'b000100`.
  - `PC_STEP` = 4.
  - Default `RESET_PC`.
  - Fetch FSM state encoding.
- **Sub-module `fetch_buffer`:** 2-entry FIFO of {pc[31:0], instr[31:0]}. It provides push, pop, flush, count and head outputs.

## Test plan
- **Reset and sequential fetch:** reset, zero-wait memory returning `addr ^ 32'hA5A5_0000`, `id_ready` = 1 → requests to 0, 4, 8 on consecutive cycles; `if_pc` = 0, 4, 8 with matching `if_instr`; `if_opcode` = `if_instr[31:26]`.
- **Backpressure:** `id_ready` = 0 for 5 cycles → exactly 2 words fetched, then `imem_req` = 0; `if_instr` and `if_pc` stable. Release → in-order delivery, no loss or duplication.
- **Wait-state memory:** ack 3 cycles after req → `imem_addr` stable throughout, one instruction per 4 cycles.
- **Redirect, idle memory:** redirect to `32'h0000_0103` with 2 entries queued → next `if_valid` = 0; next request at `32'h0000_0100`.
- **Redirect during outstanding request:** redirect to `32'h40` → old ack discarded, never visible on `if_*`; next request at `32'h40`. A second redirect to `32'h80` during DRAIN → fetch resumes at `32'h80`.
- **PC wrap and mid-run reset:** `RESET_PC` = `32'hFFFF_FFF8` → fetch addresses FFFF_FFF8, FFFF_FFFC, 0. Assert `rst_n` mid-stall → all outputs at reset values in the same cycle.
